// File: rtl/video_timing_pkg.sv
// Video timing constants for 800x600@60 and shared helpers for the sync axis generators.
package video_timing_pkg;

  // Horizontal axis (pixel clocks)
  localparam int H_ACTIVE   = 800;
  localparam int H_FRONT    = 40;
  localparam int H_SYNC     = 128;
  localparam int H_BACK     = 88;
  localparam int H_SYNC_POL = 1;
  localparam int H_WIDTH    = 11;

  // Vertical axis (lines)
  localparam int V_ACTIVE   = 600;
  localparam int V_FRONT    = 1;
  localparam int V_SYNC     = 4;
  localparam int V_BACK     = 23;
  localparam int V_SYNC_POL = 1;
  localparam int V_WIDTH    = 10;

  // Period length of one axis.
  function automatic int axis_total(input int active, input int front,
                                    input int sync_len, input int back);
    return active + front + sync_len + back;
  endfunction

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);  // 1056
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);  // 628

endpackage

// File: rtl/video_timing_frame.sv
// Frame-level timing: horizontal axis counts every clock, vertical axis steps on horizontal wrap.
module video_timing_frame
  import video_timing_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [H_WIDTH-1:0] h_match_val,
  input  logic [V_WIDTH-1:0] v_match_val,
  output logic [H_WIDTH-1:0] h_q,
  output logic [V_WIDTH-1:0] v_q,
  output logic               hsync,
  output logic               vsync,
  output logic               blank_n,
  output logic               h_wrap,
  output logic               v_wrap,
  output logic               h_match,
  output logic               v_match
);

  logic h_blank_n;
  logic v_blank_n;

  sync_axis_gen #(
    .WIDTH    (H_WIDTH),
    .ACTIVE   (H_ACTIVE),
    .FRONT    (H_FRONT),
    .SYNC     (H_SYNC),
    .BACK     (H_BACK),
    .SYNC_POL (H_SYNC_POL)
  ) u_h_axis (
    .clk       (clk),
    .rst       (rst),
    .ce        (1'b1),
    .match_val (h_match_val),
    .q         (h_q),
    .sync      (hsync),
    .blank_n   (h_blank_n),
    .wrap      (h_wrap),
    .match     (h_match)
  );

  sync_axis_gen #(
    .WIDTH    (V_WIDTH),
    .ACTIVE   (V_ACTIVE),
    .FRONT    (V_FRONT),
    .SYNC     (V_SYNC),
    .BACK     (V_BACK),
    .SYNC_POL (V_SYNC_POL)
  ) u_v_axis (
    .clk       (clk),
    .rst       (rst),
    .ce        (h_wrap),
    .match_val (v_match_val),
    .q         (v_q),
    .sync      (vsync),
    .blank_n   (v_blank_n),
    .wrap      (v_wrap),
    .match     (v_match)
  );

  // Visible only when both axes are inside their active regions.
  assign blank_n = h_blank_n & v_blank_n;

endmodule

// File: rtl/sync_axis_gen.sv
// One timing axis: position counter with registered blank, sync, wrap and match flags.
// All flags are computed from the next counter value so they line up with q in the same cycle.
module sync_axis_gen
  import video_timing_pkg::*;
#(
  parameter int WIDTH    = V_WIDTH,
  parameter int ACTIVE   = V_ACTIVE,
  parameter int FRONT    = V_FRONT,
  parameter int SYNC     = V_SYNC,
  parameter int BACK     = V_BACK,
  parameter int SYNC_POL = V_SYNC_POL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] match_val,
  output logic [WIDTH-1:0] q,
  output logic             sync,
  output logic             blank_n,
  output logic             wrap,
  output logic             match
);

  localparam int               TOTAL      = axis_total(ACTIVE, FRONT, SYNC, BACK);
  localparam int               SYNC_START = ACTIVE + FRONT;
  localparam int               SYNC_STOP  = ACTIVE + FRONT + SYNC;
  localparam logic             SYNC_ON    = (SYNC_POL != 0);
  localparam logic [WIDTH-1:0] LAST       = WIDTH'(TOTAL - 1);

  // Reject parameter sets that cannot be represented or have no sync pulse.
  generate
    if (SYNC < 1) begin : g_bad_sync_len
      $error("sync_axis_gen: SYNC must be at least 1");
    end
    if ((longint'(TOTAL) - 1) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_width
      $error("sync_axis_gen: TOTAL-1 does not fit in WIDTH bits");
    end
  endgenerate

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [31:0]      q_next_w;
  logic             sync_reg;
  logic             blank_n_reg;
  logic             wrap_reg;
  logic             match_reg;

  // Next position, wrapping from TOTAL-1 back to 0.
  always_comb begin
    q_next = q_reg + 1'b1;
    if (q_reg == LAST) begin
      q_next = '0;
    end
    q_next_w = 32'(q_next);
  end

  // Counter and flag registers. wrap is a look-ahead: it is high while q sits at
  // TOTAL-1, so a cascaded axis using it as ce steps on the same edge this axis
  // returns to 0. match only fires on a ce-driven update, never on a held q or
  // on a match_val change alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg       <= '0;
      blank_n_reg <= 1'b1;
      sync_reg    <= ~SYNC_ON;
      wrap_reg    <= 1'b0;
      match_reg   <= 1'b0;
    end else if (ce) begin
      q_reg       <= q_next;
      blank_n_reg <= (q_next_w < 32'(ACTIVE));
      sync_reg    <= ((q_next_w >= 32'(SYNC_START)) && (q_next_w < 32'(SYNC_STOP)))
                     ? SYNC_ON : ~SYNC_ON;
      wrap_reg    <= (q_next == LAST);
      match_reg   <= (q_next == match_val) && (32'(match_val) < 32'(TOTAL));
    end else begin
      wrap_reg    <= 1'b0;
      match_reg   <= 1'b0;
    end
  end

  assign q       = q_reg;
  assign sync    = sync_reg;
  assign blank_n = blank_n_reg;
  assign wrap    = wrap_reg;
  assign match   = match_reg;

endmodule

// File: tb/tb_sync_axis_gen.sv
// Self-checking bench: a vertical-default instance and an active-low horizontal instance
// run side by side; a reference model pushes expected outputs per step into scoreboards.
module tb_sync_axis_gen;

  typedef struct packed {
    logic [10:0] q;
    logic        blank_n;
    logic        sync;
    logic        wrap;
    logic        match;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce  = 1'b0;
  logic [9:0]  v_match_val = '0;
  logic [10:0] h_match_val = '0;

  logic [9:0]  v_q;
  logic        v_sync, v_blank_n, v_wrap, v_match;
  logic [10:0] h_q;
  logic        h_sync, h_blank_n, h_wrap, h_match;

  int n_checks = 0;
  int n_pass   = 0;

  obs_t exp_v_q[$];
  obs_t exp_h_q[$];
  int   mq_v = 0;
  int   mq_h = 0;

  int n_vwrap  = 0;
  int n_vmatch = 0;
  int n_hlow   = 0;

  always #5 clk = ~clk;

  sync_axis_gen u_dut_v (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .match_val (v_match_val),
    .q         (v_q),
    .sync      (v_sync),
    .blank_n   (v_blank_n),
    .wrap      (v_wrap),
    .match     (v_match)
  );

  sync_axis_gen #(
    .WIDTH    (11),
    .ACTIVE   (800),
    .FRONT    (40),
    .SYNC     (128),
    .BACK     (88),
    .SYNC_POL (0)
  ) u_dut_h (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .match_val (h_match_val),
    .q         (h_q),
    .sync      (h_sync),
    .blank_n   (h_blank_n),
    .wrap      (h_wrap),
    .match     (h_match)
  );

  // Reference behaviour of one axis for one clock edge.
  task automatic model_step(input int active, input int front, input int slen, input int back,
                            input logic pol, input int cur, input logic c, input logic r,
                            input int mv, output int nq, output obs_t o);
    int total;
    total = active + front + slen + back;
    if (r)      nq = 0;
    else if (c) nq = (cur == total - 1) ? 0 : cur + 1;
    else        nq = cur;
    o.q       = 11'(nq);
    o.blank_n = (nq < active);
    o.sync    = (nq >= active + front && nq < active + front + slen) ? pol : ~pol;
    o.wrap    = !r && c && (nq == total - 1);
    o.match   = !r && c && (nq == mv);
  endtask

  task automatic check_obs(input string tag, input obs_t act, input obs_t exp);
    n_checks++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: observed q=%0d blank_n=%b sync=%b wrap=%b match=%b, expected q=%0d blank_n=%b sync=%b wrap=%b match=%b",
                tag, act.q, act.blank_n, act.sync, act.wrap, act.match,
                exp.q, exp.blank_n, exp.sync, exp.wrap, exp.match);
  endtask

  task automatic check_int(input string tag, input int act, input int exp);
    n_checks++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, act, exp);
  endtask

  // Drive one clock of stimulus, predict, then compare both instances after the edge.
  task automatic step(input logic c, input logic r, input int mv_v, input int mv_h);
    obs_t ov, oh, av, ah;
    int   nv, nh;
    ce          = c;
    rst         = r;
    v_match_val = 10'(mv_v);
    h_match_val = 11'(mv_h);
    model_step(600, 1, 4, 23, 1'b1, mq_v, c, r, mv_v, nv, ov);
    model_step(800, 40, 128, 88, 1'b0, mq_h, c, r, mv_h, nh, oh);
    mq_v = nv;
    mq_h = nh;
    exp_v_q.push_back(ov);
    exp_h_q.push_back(oh);
    @(posedge clk);
    #1;
    av = '{q: 11'(v_q), blank_n: v_blank_n, sync: v_sync, wrap: v_wrap, match: v_match};
    ah = '{q: h_q, blank_n: h_blank_n, sync: h_sync, wrap: h_wrap, match: h_match};
    check_obs("v_axis", av, exp_v_q.pop_front());
    check_obs("h_axis", ah, exp_h_q.pop_front());
    if (v_wrap)  n_vwrap++;
    if (v_match) n_vmatch++;
    if (!h_sync) n_hlow++;
  endtask

  task automatic clear_counts();
    n_vwrap  = 0;
    n_vmatch = 0;
    n_hlow   = 0;
  endtask

  initial begin
    // Reset, then idle with match_val=0: leaving reset must not pulse match.
    step(1'b0, 1'b1, 0, 2000);
    step(1'b0, 1'b1, 0, 2000);
    clear_counts();
    step(1'b0, 1'b0, 0, 2000);
    step(1'b0, 1'b0, 0, 2000);
    check_int("no_match_after_reset", n_vmatch, 0);
    $display("reset and idle: v_q=%0d h_q=%0d", v_q, h_q);

    // Free-running period: one wrap at 627, match at the return to 0.
    clear_counts();
    for (int i = 0; i < 700; i++) step(1'b1, 1'b0, 0, 2000);
    check_int("free_run_wraps", n_vwrap, 1);
    check_int("free_run_match0", n_vmatch, 1);
    $display("free run 700 clks: v_q=%0d wraps=%0d matches=%0d", v_q, n_vwrap, n_vmatch);

    // Alternating ce: match at 5 once, not repeated while q holds.
    step(1'b0, 1'b1, 5, 2000);
    clear_counts();
    for (int i = 0; i < 40; i++) step((i % 2) == 0, 1'b0, 5, 2000);
    check_int("toggle_ce_q", int'(v_q), 20);
    check_int("toggle_ce_match_once", n_vmatch, 1);
    $display("toggled ce 40 clks: v_q=%0d matches=%0d", v_q, n_vmatch);

    // Reset in the middle of the sync pulse, then match_val=0 waits for a full wrap.
    step(1'b0, 1'b1, 0, 2000);
    for (int i = 0; i < 603; i++) step(1'b1, 1'b0, 0, 2000);
    check_int("mid_sync_high", int'(v_sync), 1);
    step(1'b1, 1'b1, 0, 2000);
    clear_counts();
    for (int i = 0; i < 627; i++) step(1'b1, 1'b0, 0, 2000);
    check_int("no_match_before_wrap", n_vmatch, 0);
    step(1'b1, 1'b0, 0, 2000);
    check_int("match_at_wrap", n_vmatch, 1);
    $display("reset at q=603 then one period: v_q=%0d matches=%0d", v_q, n_vmatch);

    // Out-of-range match_val, then rewritten in flight; active-low H sync width.
    step(1'b0, 1'b1, 700, 2000);
    clear_counts();
    for (int i = 0; i < 1256; i++) step(1'b1, 1'b0, 700, 2000);
    check_int("no_match_out_of_range", n_vmatch, 0);
    check_int("h_sync_low_width", n_hlow, 128);
    clear_counts();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 700, 2000);
    check_int("q_at_rewrite", int'(v_q), 5);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 10, 2000);
    check_int("rewritten_match_once", n_vmatch, 1);
    $display("match_val 700 then 10: v_q=%0d matches=%0d", v_q, n_vmatch);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
